// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and sizing helper for the sequential multiplier
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/seq_multiplier_dpath.sv
// rtl/seq_multiplier_dpath.sv - operand, accumulator and counter registers with shift-add and negate logic
module seq_multiplier_dpath
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic               commit,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               last_step,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = clog2(WIDTH + 1);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               mode_reg;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;

    // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    always_comb begin
        a_mag = (mode_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
        b_mag = (mode_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    end

    assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_reg};
    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= 1'b0;
            neg      <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            product  <= '0;
        end else begin
            if (capture) begin
                a_reg    <= multiplier;
                b_reg    <= multiplicand;
                mode_reg <= signed_mode;
            end
            if (load) begin
                a_reg <= a_mag;
                b_reg <= b_mag;
                neg   <= mode_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                acc   <= '0;
                cnt   <= CW'(WIDTH);
            end
            // The carry out of the add becomes the new top bit after the right shift.
            if (step) begin
                if (a_reg[0]) begin
                    acc <= {sum, acc[WIDTH-1:1]};
                end else begin
                    acc <= {1'b0, acc[2*WIDTH-1:1]};
                end
                a_reg <= a_reg >> 1;
                cnt   <= cnt - CW'(1);
            end
            if (fix && neg) begin
                acc <= -acc;
            end
            if (commit) begin
                product <= acc;
            end
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - control FSM of the shift-add multiplier with busy/done status
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t state;
    logic   capture;
    logic   load;
    logic   step;
    logic   fix;
    logic   commit;
    logic   last_step;

    assign capture = (state == IDLE) && start;
    assign load    = (state == INIT);
    assign step    = (state == CALC);
    assign fix     = (state == FIX);
    assign commit  = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= INIT;
                        busy  <= 1'b1;
                    end
                end
                INIT: state <= CALC;
                CALC: begin
                    if (last_step) begin
                        state <= FIX;
                    end
                end
                FIX:  state <= DONE;
                // done rises as the product register loads, so they are valid together.
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    seq_multiplier_dpath #(
        .WIDTH(WIDTH)
    ) u_dpath (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .load        (load),
        .step        (step),
        .fix         (fix),
        .commit      (commit),
        .signed_mode (signed_mode),
        .multiplier  (multiplier),
        .multiplicand(multiplicand),
        .last_step   (last_step),
        .product     (product)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed vector bench for seq_multiplier at WIDTH 4 and 8
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          w;
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .multiplier(a4), .multiplicand(b4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplier(a8), .multiplicand(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic op(input int w, input logic sm, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
        @(negedge clk);
        if (w == 4) begin
            start4 = 1'b1; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        check("busy_after_accept", (w == 4) ? busy4 : busy8, 1'b1);
        lat = 0;
        p   = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if ((w == 4) ? done4 : done8) begin
                lat = i;
                p   = (w == 4) ? {8'h00, prod4} : prod8;
                check("busy_low_in_done_cycle", (w == 4) ? busy4 : busy8, 1'b0);
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] p;
        int          lat;
        int          dones;
        int          first_done;
        int          second_done;

        vecs[0]  = '{4, 1'b0, 8'h06, 8'h03, 16'h0012, 7};
        vecs[1]  = '{4, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 7};
        vecs[2]  = '{4, 1'b1, 8'h0D, 8'h05, 16'h00F1, 7};
        vecs[3]  = '{4, 1'b0, 8'h0D, 8'h05, 16'h0041, 7};
        vecs[4]  = '{4, 1'b1, 8'h08, 8'h08, 16'h0040, 7};
        vecs[5]  = '{4, 1'b1, 8'h08, 8'h07, 16'h00C8, 7};
        vecs[6]  = '{4, 1'b1, 8'h00, 8'h0F, 16'h0000, 7};
        vecs[7]  = '{4, 1'b1, 8'h07, 8'h0F, 16'h00F9, 7};
        vecs[8]  = '{8, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 11};
        vecs[9]  = '{8, 1'b1, 8'h80, 8'h01, 16'hFF80, 11};
        vecs[10] = '{8, 1'b0, 8'h80, 8'h01, 16'h0080, 11};

        rst = 1'b0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy4", busy4, 1'b0);
        check("reset_done4", done4, 1'b0);
        check("reset_prod4", prod4, 8'h00);
        check("reset_prod8", prod8, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            op(vecs[i].w, vecs[i].sm, vecs[i].a, vecs[i].b, p, lat);
            check($sformatf("vec%0d_product", i), p, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // product holds after done, done is a single pulse
        op(4, 1'b0, 8'h06, 8'h03, p, lat);
        check("hold_first", p, 16'h0012);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_product", prod4, 8'h12);
            check("hold_done_low", done4, 1'b0);
        end

        // start while busy with changed operands is ignored
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'd6; b4 = 4'd3;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        dones = 0;
        first_done = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start4 = 1'b1; a4 = 4'd2; b4 = 4'd2; sm4 = 1'b1;
            end else begin
                start4 = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done4) begin
                dones++;
                if (first_done == 0) begin
                    first_done = i;
                    check("busy_start_product", prod4, 8'h12);
                end
            end
        end
        check("busy_start_dones", dones, 1);
        check("busy_start_edge", first_done, 7);

        // start held high: back-to-back acceptance
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'd3; b4 = 4'd3;
        @(posedge clk);
        #1;
        first_done = 0;
        second_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                if (first_done == 0) first_done = i;
                else if (second_done == 0) second_done = i;
            end
        end
        @(negedge clk);
        start4 = 1'b0;
        check("held_start_first", first_done, 7);
        check("held_start_second", second_done, 15);
        check("held_start_product", prod4, 8'h09);
        repeat (12) @(posedge clk);

        // reset mid-operation abandons the operation
        op(4, 1'b0, 8'h06, 8'h03, p, lat);
        check("pre_reset_product", p, 16'h0012);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd5; sm4 = 1'b0;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_busy", busy4, 1'b0);
        check("midreset_done", done4, 1'b0);
        check("midreset_product", prod4, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done4) dones++;
        end
        check("midreset_no_done", dones, 0);
        op(4, 1'b0, 8'h02, 8'h07, p, lat);
        check("after_reset_product", p, 16'h000E);
        check("after_reset_latency", lat, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised shift-add sequential multiplier: generalises the fixed 4-bit multiplier to any operand width WIDTH, adds a per-operation signed/unsigned mode, and provides busy/done status. It sits behind the same start-pulse control as the current multiplier. Operands are captured once, and one multiplier bit is retired per clock. The product register holds its value until the next operation completes.

## Interface
- WIDTH, default 4: operand width in bits; legal range 2–32.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-low. Sampled low on a clk edge → reset state.
- start  in  1  request; accepted only in IDLE.
- signed_mode  in  1  captured with start; 1 = two's-complement operands and product, 0 = unsigned.
- multiplier  in  WIDTH  operand A; captured on the accepting edge.
- multiplicand  in  WIDTH  operand B; captured on the accepting edge.
- busy  out  1  high from the cycle after acceptance through the DONE state.
- done  out  1  single-cycle pulse; product is valid in that cycle.
- product  out  2*WIDTH  result register; held between operations.

## Operation
- States: IDLE → INIT → CALC → FIX → DONE → IDLE.
- IDLE: start=1 → capture operands and signed_mode, go to INIT. start=0 → stay in IDLE.
- INIT:
  - signed_mode=1: compute the magnitudes of both operands and neg = A[MSB] ^ B[MSB].
  - signed_mode=0: use the operands unchanged and set neg=0.
  - Clear the accumulator and set the bit counter to WIDTH.
- CALC, once per cycle:
  - If the multiplier LSB is 1, add the multiplicand magnitude into the upper half of the accumulator.
  - Shift the {carry, accumulator} pair right by 1, shifting the multiplier with it.
  - Decrement the counter.
  - Leave CALC when the counter reaches 0, giving exactly WIDTH CALC cycles.
- FIX: if neg=1, the accumulator becomes its two's-complement negation modulo 2^(2*WIDTH).
- DONE: load the product from the accumulator, assert done, return to IDLE.
- Width rules:
  - Accumulator is 2*WIDTH bits plus a 1-bit carry during the add.
  - Magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), which fits in WIDTH unsigned bits; no overflow is possible.
  - A signed product always fits in 2*WIDTH bits.
- start while busy: ignored, with no effect on the current operation. Input changes after capture have no effect.
- start held high through DONE: a new operation is accepted on the first IDLE cycle.
- Reset value of every output: busy=0, done=0, product=0. The FSM goes to IDLE and the accumulator and counter clear.
- Reset mid-operation: the operation is abandoned and no done is produced. product=0 on the cycle after the reset edge.

## Timing
- Edge 0: start sampled in IDLE.
- Edge 1: INIT.
- Edges 2 … WIDTH+1: CALC.
- Edge WIDTH+2: FIX.
- Edge WIDTH+3: DONE, so done=1 and product is valid during the cycle following edge WIDTH+3.
- Total latency is WIDTH+3 edges from acceptance, which is 7 for WIDTH=4 and stays within the existing 10-clock budget.
- busy is high from edge 1 until the edge that leaves DONE.
- Earliest next acceptance is WIDTH+4 edges after the previous one.
- Latency is fixed: independent of operand values and of mode.

## Structure
- Shared package mult_pkg:
  - state enum {IDLE, INIT, CALC, FIX, DONE}.
  - Counter-width function clog2(WIDTH+1).
- Natural sub-module: seq_multiplier_dpath. It holds the operand, accumulator and counter registers, the adder and the negate logic.
- The FSM stays in seq_multiplier and drives the datapath through load/step/fix/commit strobes.

## Test plan
- WIDTH=4, unsigned, 0110 × 0011, start pulsed one cycle → done on edge 7, product=8'b00010010. product then holds for 5 further clocks.
- WIDTH=4, unsigned, 15 × 15 → product=8'hE1. WIDTH=4, signed, −3 × 5 (4'hD, 4'h5) → product=8'hF1.
- WIDTH=4, signed, −8 × −8 → 8'h40. Signed −8 × 7 → 8'hC8. Signed 0 × −1 → 8'h00.
- WIDTH=8, unsigned, 255 × 255 → 16'hFE01 after 11 edges. Signed 8'h80 × 8'h01 → 16'hFF80.
- Start 6 × 3; pulse start again with 2 × 2 at edge 3 and change the operands → result is still 18, with exactly one done pulse.
- Start 6 × 3 → result 18. Start 5 × 5; drive rst=0 at edge 4 → busy=0, done=0, product=0 next cycle, and no done follows. A fresh 2 × 7 then gives 8'h0E.
